// File: rtl/context_sequencer.sv
// rtl/context_sequencer.sv - context program store and sequencer feeding the PE context and global enable.
// Host loads context/control words while idle; a start pulse walks the program with jumps, stalls and halt.
module context_sequencer #(
   parameter int CONTEXT_WIDTH      = 64,
   parameter int CONTEXT_DEPTH      = 256,
   parameter int CONTEXT_ADDR_WIDTH = 8
) (
   input  logic                          CLK_I,
   input  logic                          RST_N_I,
   input  logic                          LOAD_EN_I,
   input  logic [CONTEXT_ADDR_WIDTH-1:0] LOAD_ADDR_I,
   input  logic [CONTEXT_WIDTH-1:0]      LOAD_CONTEXT_I,
   input  logic [CONTEXT_ADDR_WIDTH+2:0] LOAD_CTRL_I,
   input  logic                          START_I,
   input  logic [CONTEXT_ADDR_WIDTH-1:0] START_ADDR_I,
   input  logic                          STALL_I,
   input  logic                          PBOX_I,
   output logic [CONTEXT_WIDTH-1:0]      CONTEXT_O,
   output logic                          EN_GLOBAL_O,
   output logic [CONTEXT_ADDR_WIDTH-1:0] PC_O,
   output logic                          BUSY_O,
   output logic                          DONE_O
);

   localparam int CTRL_WIDTH = CONTEXT_ADDR_WIDTH + 3;
   localparam logic [CONTEXT_ADDR_WIDTH-1:0] PC_ONE = 1;

   typedef enum logic [1:0] {IDLE, FETCH, RUN, DONE} state_t;

   state_t                        state;
   logic [CONTEXT_WIDTH-1:0]      ctx_mem  [CONTEXT_DEPTH];
   logic [CTRL_WIDTH-1:0]         ctrl_mem [CONTEXT_DEPTH];
   logic [CTRL_WIDTH-1:0]         ctrl_q;
   logic [CONTEXT_ADDR_WIDTH-1:0] next_pc;
   logic                          write_en;
   logic                          halt;
   logic                          take_jump;

   assign write_en    = LOAD_EN_I && (state == IDLE);
   assign halt        = ctrl_q[CONTEXT_ADDR_WIDTH+2];
   assign take_jump   = ctrl_q[CONTEXT_ADDR_WIDTH] &&
                        (!ctrl_q[CONTEXT_ADDR_WIDTH+1] || PBOX_I);
   assign EN_GLOBAL_O = (state == RUN) && !STALL_I;

   // Read address; CONTEXT_O/ctrl_q act as the synchronous read register so contexts follow back to back.
   always_comb begin
      next_pc = PC_O;
      case (state)
         IDLE: begin
            if (START_I) next_pc = START_ADDR_I;
         end
         RUN: begin
            if (!STALL_I && !halt)
               next_pc = take_jump ? ctrl_q[CONTEXT_ADDR_WIDTH-1:0] : PC_O + PC_ONE;
         end
         default: ;
      endcase
   end

   always_ff @(posedge CLK_I) begin
      if (write_en) begin
         ctx_mem[LOAD_ADDR_I]  <= LOAD_CONTEXT_I;
         ctrl_mem[LOAD_ADDR_I] <= LOAD_CTRL_I;
      end
   end

   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state     <= IDLE;
         CONTEXT_O <= '0;
         ctrl_q    <= '0;
         PC_O      <= '0;
         BUSY_O    <= 1'b0;
         DONE_O    <= 1'b0;
      end else begin
         DONE_O <= 1'b0;
         case (state)
            IDLE: begin
               if (START_I) begin
                  state  <= FETCH;
                  PC_O   <= START_ADDR_I;
                  BUSY_O <= 1'b1;
               end
            end
            FETCH: begin
               CONTEXT_O <= ctx_mem[next_pc];
               ctrl_q    <= ctrl_mem[next_pc];
               state     <= RUN;
            end
            RUN: begin
               if (!STALL_I) begin
                  if (halt) begin
                     state  <= DONE;
                     BUSY_O <= 1'b0;
                     DONE_O <= 1'b1;
                  end else begin
                     PC_O      <= next_pc;
                     CONTEXT_O <= ctx_mem[next_pc];
                     ctrl_q    <= ctrl_mem[next_pc];
                  end
               end
            end
            DONE: begin
               state <= IDLE;
            end
            default: begin
               state  <= IDLE;
               BUSY_O <= 1'b0;
            end
         endcase
      end
   end

endmodule
